branch_resolve_unit: RTL and testbench

Multi-slot, pipelined branch resolution unit for the VLIW execute stage. Each cycle it accepts one bundle of LANES branch-capable slots and evaluates every slot's condition and target in parallel. It selects the oldest (lowest-index) taken slot, kills younger slots, and emits one registered redirect to fetch. A valid/ready handshake applies on both sides.

---
 rtl/branch_resolve_unit.sv | 196 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Two-stage branch resolution for a VLIW execute bundle. Every slot's
//   condition and target are evaluated in parallel (S1). The lowest-index
//   taken slot is then selected into the registered redirect outputs (S2),
//   and all younger slots are marked for kill.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   flush                      synchronous kill of S1 and S2
//   in_valid / in_ready        bundle handshake
//   in_slot_valid, in_is_jmp, in_is_imm_type, in_zero_ext   per-slot flags
//   in_op (2b/slot)            0 BEQ, 1 BNE, 2 BLT(U), 3 BGE(U)
//   in_pc, in_rs1, in_rs2      per-slot operands (XLEN each)
//   in_imm                     per-slot immediate (IMM_W each)
//   out_valid / out_ready      result handshake
//   out_taken, out_slot, out_target, out_kill_mask, out_illegal, out_misalign
//   out_link                   per-slot pc+4 (only when BRANCH_LINK_EN is defined)
//
// Configuration macro: BRANCH_LINK_EN

module branch_resolve_unit #(
    parameter int LANES  = 4,
    parameter int XLEN   = 32,
    parameter int IMM_W  = 22,
    parameter int SLOT_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_slot_valid,
    input  logic [LANES-1:0]        in_is_jmp,
    input  logic [LANES-1:0]        in_is_imm_type,
    input  logic [LANES-1:0]        in_zero_ext,
    input  logic [2*LANES-1:0]      in_op,
    input  logic [XLEN*LANES-1:0]   in_pc,
    input  logic [XLEN*LANES-1:0]   in_rs1,
    input  logic [XLEN*LANES-1:0]   in_rs2,
    input  logic [IMM_W*LANES-1:0]  in_imm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_taken,
    output logic [SLOT_W-1:0]       out_slot,
    output logic [XLEN-1:0]         out_target,
    output logic [LANES-1:0]        out_kill_mask,
    output logic [LANES-1:0]        out_illegal,
    output logic                    out_misalign
`ifdef BRANCH_LINK_EN
    ,
    output logic [XLEN*LANES-1:0]   out_link
`endif
);

    logic s1_valid;
    logic s2_adv, squash;

    // S2 drains when empty or consumed; S1 can only move when S2 moves.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = flush || !s1_valid || s2_adv;
    // A consumed redirect means whatever sits in S1 is on the wrong path.
    assign squash   = out_valid && out_ready && out_taken;

    // ---------------- per-slot evaluation (feeds S1) ----------------
    logic [LANES-1:0]           c_taken, c_illegal;
    logic [LANES-1:0][XLEN-1:0] c_target;
`ifdef BRANCH_LINK_EN
    logic [LANES-1:0][XLEN-1:0] c_link;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_slot
        logic [XLEN-1:0]  pc, rs1, rs2, sext12, sextj, jalr_sum;
        logic [IMM_W-1:0] imm;
        logic [1:0]       op;
        logic             lt, cond;

        assign pc   = in_pc [g*XLEN +: XLEN];
        assign rs1  = in_rs1[g*XLEN +: XLEN];
        assign rs2  = in_rs2[g*XLEN +: XLEN];
        assign imm  = in_imm[g*IMM_W +: IMM_W];
        assign op   = in_op [g*2 +: 2];

        // Branch/JALR use a 12-bit immediate; only JAL sees the full field.
        assign sext12   = {{(XLEN-12){imm[11]}}, imm[11:0]};
        assign sextj    = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
        assign jalr_sum = rs1 + sext12;

        assign lt = in_zero_ext[g] ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));

        always_comb begin
            cond = 1'b0;
            case (op)
                2'd0: cond = (rs1 == rs2);
                2'd1: cond = (rs1 != rs2);
                2'd2: cond = lt;
                2'd3: cond = !lt;
                default: cond = 1'b0;
            endcase
        end

        assign c_taken[g]   = in_slot_valid[g] &&
                              (in_is_jmp[g] || (!in_is_imm_type[g] && cond));
        assign c_illegal[g] = in_slot_valid[g] && !in_is_jmp[g] && in_is_imm_type[g];
        assign c_target[g]  = (in_is_jmp[g] && in_is_imm_type[g]) ?
                              {jalr_sum[XLEN-1:1], 1'b0} :
                              pc + (in_is_jmp[g] ? sextj : sext12);
`ifdef BRANCH_LINK_EN
        assign c_link[g]    = pc + XLEN'(4);
`endif
    end

    // ---------------- S1 ----------------
    logic [LANES-1:0]           s1_taken, s1_illegal;
    logic [LANES-1:0][XLEN-1:0] s1_target;
`ifdef BRANCH_LINK_EN
    logic [LANES-1:0][XLEN-1:0] s1_link;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_taken   <= '0;
            s1_illegal <= '0;
            s1_target  <= '0;
`ifdef BRANCH_LINK_EN
            s1_link    <= '0;
`endif
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_taken   <= c_taken;
                s1_illegal <= c_illegal;
                s1_target  <= c_target;
`ifdef BRANCH_LINK_EN
                s1_link    <= c_link;
`endif
            end
        end
    end

    // ---------------- priority select ----------------
    logic              sel_taken;
    logic [SLOT_W-1:0] sel_slot;
    logic [XLEN-1:0]   sel_target;
    logic [LANES-1:0]  sel_kill;

    // Walk oldest to youngest; every slot after the first taken one is killed.
    always_comb begin
        sel_taken  = 1'b0;
        sel_slot   = '0;
        sel_target = '0;
        sel_kill   = '0;
        for (int i = 0; i < LANES; i++) begin
            sel_kill[i] = sel_taken;
            if (s1_taken[i] && !sel_taken) begin
                sel_taken  = 1'b1;
                sel_slot   = SLOT_W'(i);
                sel_target = s1_target[i];
            end
        end
    end

    // ---------------- S2 / outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_taken     <= 1'b0;
            out_slot      <= '0;
            out_target    <= '0;
            out_kill_mask <= '0;
            out_illegal   <= '0;
            out_misalign  <= 1'b0;
`ifdef BRANCH_LINK_EN
            out_link      <= '0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid && !squash;
            if (s1_valid && !squash) begin
                out_taken     <= sel_taken;
                out_slot      <= sel_slot;
                out_target    <= sel_target;
                out_kill_mask <= sel_kill;
                out_illegal   <= s1_illegal;
                out_misalign  <= sel_taken && (sel_target[1:0] != 2'b00);
`ifdef BRANCH_LINK_EN
                out_link      <= s1_link;
`endif
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   in_slot_valid, in_is_jmp, in_is_imm_type, in_zero_ext;
    logic [7:0]   in_op;
    logic [127:0] in_pc, in_rs1, in_rs2;
    logic [87:0]  in_imm;
    logic         out_taken, out_misalign;
    logic [1:0]   out_slot;
    logic [31:0]  out_target;
    logic [3:0]   out_kill_mask, out_illegal;
`ifdef BRANCH_LINK_EN
    logic [127:0] out_link;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_slot_valid(in_slot_valid), .in_is_jmp(in_is_jmp),
        .in_is_imm_type(in_is_imm_type), .in_zero_ext(in_zero_ext),
        .in_op(in_op), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_slot(out_slot), .out_target(out_target),
        .out_kill_mask(out_kill_mask), .out_illegal(out_illegal),
        .out_misalign(out_misalign)
`ifdef BRANCH_LINK_EN
        , .out_link(out_link)
`endif
    );

    typedef struct {
        logic [3:0]        sv, jmp, immt, zext;
        logic [3:0][1:0]   op;
        logic [3:0][31:0]  pc, rs1, rs2;
        logic [3:0][21:0]  imm;
    } bundle_t;

    typedef struct packed {
        logic             taken;
        logic [1:0]       slot;
        logic [31:0]      target;
        logic [3:0]       kill;
        logic [3:0]       ill;
        logic             mis;
        logic [3:0][31:0] link;
    } res_t;

    typedef struct {
        bundle_t    b;
        logic       taken;
        logic [1:0] slot;
        logic [31:0] target;
        logic [3:0] kill, ill;
        logic       mis;
    } vec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t q[$];
    vec_t tv[8];
    bundle_t idle, ba, bb, bc;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bundle_t nop();
        bundle_t b;
        b.sv = '0; b.jmp = '0; b.immt = '0; b.zext = '0; b.op = '0;
        b.pc = '0; b.rs1 = '0; b.rs2 = '0; b.imm = '0;
        return b;
    endfunction

    function automatic void slot(inout bundle_t b, input int i, input logic j, t, z,
                                 input logic [1:0] op, input logic [31:0] pc, r1, r2,
                                 input logic [21:0] imm);
        b.sv[i] = 1'b1; b.jmp[i] = j; b.immt[i] = t; b.zext[i] = z; b.op[i] = op;
        b.pc[i] = pc; b.rs1[i] = r1; b.rs2[i] = r2; b.imm[i] = imm;
    endfunction

    // Reference: evaluate each slot from the ISA rules with 64-bit arithmetic,
    // then pick the first taken one.
    function automatic res_t model(input bundle_t b);
        res_t r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            longint ua, ub, sa, sb, s12, s22, tgt;
            bit tk;
            ua  = b.rs1[i];
            ub  = b.rs2[i];
            sa  = $signed(b.rs1[i]);
            sb  = $signed(b.rs2[i]);
            s12 = b.imm[i] % 4096;
            if (s12 >= 2048) s12 = s12 - 4096;
            s22 = b.imm[i];
            if (s22 >= (1 << 21)) s22 = s22 - (1 << 22);
            tk  = 0;
            tgt = 0;
            r.link[i] = 32'((longint'(b.pc[i]) + 4) & 64'hFFFF_FFFF);
            if (b.sv[i]) begin
                if (!b.jmp[i] && b.immt[i]) r.ill[i] = 1'b1;
                else if (b.jmp[i] && b.immt[i]) begin
                    tk = 1; tgt = ((ua + s12) & 64'hFFFF_FFFF) / 2 * 2;
                end else if (b.jmp[i]) begin
                    tk = 1; tgt = longint'(b.pc[i]) + s22;
                end else begin
                    tgt = longint'(b.pc[i]) + s12;
                    case (b.op[i])
                        2'd0: tk = (ua == ub);
                        2'd1: tk = (ua != ub);
                        2'd2: tk = b.zext[i] ? (ua < ub) : (sa < sb);
                        default: tk = b.zext[i] ? (ua >= ub) : (sa >= sb);
                    endcase
                end
            end
            if (tk && !r.taken) begin
                r.taken  = 1'b1;
                r.slot   = 2'(i);
                r.target = 32'(tgt & 64'hFFFF_FFFF);
                r.kill   = 4'((15 << (i + 1)) & 15);
            end
        end
        r.mis = r.taken && (r.target % 4 != 0);
        return r;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b = nop();
        for (int i = 0; i < 4; i++) begin
            int kind;
            kind = $urandom_range(0, 7);
            b.sv[i]   = ($urandom_range(0, 4) != 0);
            b.jmp[i]  = (kind == 4 || kind == 5);
            b.immt[i] = (kind == 5 || kind == 6);
            b.zext[i] = $urandom_range(0, 1);
            b.op[i]   = 2'($urandom_range(0, 3));
            b.pc[i]   = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            b.rs1[i]  = $urandom;
            b.rs2[i]  = ($urandom_range(0, 2) == 0) ? b.rs1[i] : $urandom;
            b.imm[i]  = 22'($urandom);
        end
        return b;
    endfunction

    // One clock: drive at negedge, sample 1 time unit later, score handshakes
    // that will complete on the coming posedge.
    task automatic cycle(input bundle_t b, input bit iv, input bit ordy, input bit fl);
        res_t t;
        @(negedge clk);
        in_slot_valid = b.sv; in_is_jmp = b.jmp; in_is_imm_type = b.immt;
        in_zero_ext = b.zext; in_op = b.op; in_pc = b.pc; in_rs1 = b.rs1;
        in_rs2 = b.rs2; in_imm = b.imm;
        in_valid = iv; out_ready = ordy; flush = fl;
        #1;
        if (fl) q.delete();
        else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL spurious_out: got out_valid=1 expected no pending result");
                end else begin
                    chk("out_result",
                        {out_taken, out_slot, out_target, out_kill_mask, out_illegal, out_misalign},
                        {q[0].taken, q[0].slot, q[0].target, q[0].kill, q[0].ill, q[0].mis});
`ifdef BRANCH_LINK_EN
                    chk("out_link", out_link, q[0].link);
`endif
                end
            end
            if (out_valid && out_ready && q.size() > 0) begin
                t = q.pop_front();
                if (t.taken && q.size() > 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(b));
        end
    endtask

    initial begin
        idle = nop();
        for (int k = 0; k < 8; k++) tv[k].b = nop();
        slot(tv[0].b, 1, 0, 0, 0, 2'd0, 32'h100, 32'd5, 32'd5, 22'h010);
        {tv[0].taken, tv[0].slot, tv[0].target, tv[0].kill, tv[0].ill, tv[0].mis} = {1'b1, 2'd1, 32'h110, 4'b1100, 4'b0000, 1'b0};
        slot(tv[1].b, 0, 0, 0, 1, 2'd2, 32'h300, 32'hFFFF_FFFF, 32'd1, 22'h020);
        slot(tv[1].b, 2, 1, 0, 0, 2'd0, 32'h200, 32'd0, 32'd0, 22'h3FFFFC);
        {tv[1].taken, tv[1].slot, tv[1].target, tv[1].kill, tv[1].ill, tv[1].mis} = {1'b1, 2'd2, 32'h1FC, 4'b1000, 4'b0000, 1'b0};
        tv[2].b = tv[1].b; tv[2].b.zext[0] = 1'b0;
        {tv[2].taken, tv[2].slot, tv[2].target, tv[2].kill, tv[2].ill, tv[2].mis} = {1'b1, 2'd0, 32'h320, 4'b1110, 4'b0000, 1'b0};
        slot(tv[3].b, 0, 1, 1, 0, 2'd0, 32'h40, 32'h1001, 32'd0, 22'h002);
        slot(tv[3].b, 1, 0, 1, 0, 2'd0, 32'h50, 32'd0, 32'd0, 22'h000);
        {tv[3].taken, tv[3].slot, tv[3].target, tv[3].kill, tv[3].ill, tv[3].mis} = {1'b1, 2'd0, 32'h1002, 4'b1110, 4'b0010, 1'b1};
        slot(tv[4].b, 1, 0, 0, 0, 2'd1, 32'h60, 32'd7, 32'd7, 22'h004);
        slot(tv[4].b, 3, 0, 1, 0, 2'd0, 32'h70, 32'd1, 32'd1, 22'h004);
        {tv[4].taken, tv[4].slot, tv[4].target, tv[4].kill, tv[4].ill, tv[4].mis} = {1'b0, 2'd0, 32'h0, 4'b0000, 4'b1000, 1'b0};
        slot(tv[5].b, 2, 0, 0, 1, 2'd3, 32'h80, 32'd1, 32'd2, 22'h004);
        slot(tv[5].b, 3, 0, 0, 0, 2'd1, 32'h1000, 32'd1, 32'd2, 22'h1557F0);
        {tv[5].taken, tv[5].slot, tv[5].target, tv[5].kill, tv[5].ill, tv[5].mis} = {1'b1, 2'd3, 32'h17F0, 4'b0000, 4'b0000, 1'b0};
        slot(tv[6].b, 1, 0, 0, 0, 2'd3, 32'h90, 32'hFFFF_FFF0, 32'd5, 22'h004);
        slot(tv[6].b, 2, 0, 0, 1, 2'd3, 32'h2000, 32'hFFFF_FFF0, 32'd5, 22'h000FFC);
        {tv[6].taken, tv[6].slot, tv[6].target, tv[6].kill, tv[6].ill, tv[6].mis} = {1'b1, 2'd2, 32'h1FFC, 4'b1000, 4'b0000, 1'b0};
        slot(tv[7].b, 0, 1, 0, 0, 2'd0, 32'h10000, 32'd0, 32'd0, 22'h200000);
        slot(tv[7].b, 1, 1, 0, 0, 2'd0, 32'h20000, 32'd0, 32'd0, 22'h000008);
        {tv[7].taken, tv[7].slot, tv[7].target, tv[7].kill, tv[7].ill, tv[7].mis} = {1'b1, 2'd0, 32'hFFE1_0000, 4'b1110, 4'b0000, 1'b0};

        ba = nop(); slot(ba, 0, 0, 1, 0, 2'd0, 32'h4, 32'd0, 32'd0, 22'h0);
        bb = nop(); slot(bb, 1, 0, 1, 0, 2'd0, 32'h8, 32'd0, 32'd0, 22'h0);
        slot(bb, 0, 0, 0, 0, 2'd1, 32'h8, 32'd3, 32'd3, 22'h10);
        bc = nop(); slot(bc, 2, 0, 1, 0, 2'd0, 32'hC, 32'd0, 32'd0, 22'h0);

        // reset state
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_slot_valid = '0; in_is_jmp = '0; in_is_imm_type = '0; in_zero_ext = '0;
        in_op = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fields", {out_taken, out_slot, out_target, out_kill_mask, out_illegal, out_misalign}, 0);
`ifdef BRANCH_LINK_EN
        chk("rst_link", out_link, 0);
`endif
        @(negedge clk); rst_n = 1'b1;

        // table: single bundle, 2-cycle latency, field check
        for (int k = 0; k < 8; k++) begin
            cycle(tv[k].b, 1, 1, 0);
            cycle(idle, 0, 1, 0);
            chk($sformatf("vec%0d_gap", k), out_valid, 0);
            cycle(idle, 0, 1, 0);
            chk($sformatf("vec%0d_valid", k), out_valid, 1);
            chk($sformatf("vec%0d_fields", k),
                {out_taken, out_slot, out_target, out_kill_mask, out_illegal, out_misalign},
                {tv[k].taken, tv[k].slot, tv[k].target, tv[k].kill, tv[k].ill, tv[k].mis});
        end

        // backpressure: two accepts then stall, results in order
        cycle(ba, 1, 0, 0); chk("bp_rdy_a", in_ready, 1);
        cycle(bb, 1, 0, 0); chk("bp_rdy_b", in_ready, 1);
        cycle(bc, 1, 0, 0); chk("bp_rdy_c0", in_ready, 0);
        cycle(bc, 1, 0, 0); chk("bp_rdy_c1", in_ready, 0);
        cycle(bc, 1, 0, 0); chk("bp_hold_ill", out_illegal, 4'b0001);
        cycle(bc, 1, 1, 0); chk("bp_rdy_c2", in_ready, 1);
        for (int k = 0; k < 4; k++) cycle(idle, 0, 1, 0);
        chk("bp_drained", q.size(), 0);

        // auto-squash: taken result consumed while next bundle sits in S1
        cycle(tv[0].b, 1, 1, 0);
        cycle(bb, 1, 1, 0);
        cycle(bc, 1, 1, 0); chk("sq_taken_out", out_taken, 1);
        cycle(idle, 0, 1, 0); chk("sq_gap", out_valid, 0);
        cycle(idle, 0, 1, 0); chk("sq_next_valid", out_valid, 1);
        chk("sq_next_ill", out_illegal, 4'b0100);
        cycle(idle, 0, 1, 0);

        // flush with both stages full
        cycle(ba, 1, 0, 0);
        cycle(bb, 1, 0, 0);
        cycle(bc, 1, 0, 1); chk("fl_rdy", in_ready, 1);
        cycle(idle, 0, 1, 0); chk("fl_v0", out_valid, 0);
        cycle(idle, 0, 1, 0); chk("fl_v1", out_valid, 0);
        cycle(idle, 0, 1, 0); chk("fl_v2", out_valid, 0);

        // async reset with both stages full
        cycle(tv[0].b, 1, 0, 0);
        cycle(tv[3].b, 1, 0, 0);
        cycle(idle, 0, 0, 0); chk("rst_pre_target", out_target, 32'h110);
        #2; rst_n = 1'b0; #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_target", out_target, 0);
        chk("rst_mid_rdy", in_ready, 1);
`ifdef BRANCH_LINK_EN
        chk("rst_mid_link", out_link, 0);
`endif
        q.delete();
        @(negedge clk); rst_n = 1'b1;
        cycle(idle, 0, 1, 0); chk("rst_post_valid", out_valid, 0);
        cycle(idle, 0, 1, 0); chk("rst_post_valid2", out_valid, 0);

        // randomized traffic against the reference model
        for (int k = 0; k < 500; k++) begin
            bit fl, iv, ordy;
            fl   = ($urandom_range(0, 39) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
            cycle(rand_bundle(), iv, ordy, fl);
        end
        for (int k = 0; k < 4; k++) cycle(idle, 0, 1, 0);
        chk("rand_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
